// File: rtl/term_budget_limiter_if.sv
// ---------------------------------------------------------------------------
// term_budget_limiter_if
//
// Purpose: valid/ready beat bundle for one term stream, shared by the
// input and output sides of term_budget_limiter.
//
// Signals:
//   valid  beat valid (producer -> consumer)
//   ready  consumer can take the beat (consumer -> producer)
//   last   final beat of the current group
//   term   term-present bit per lane
//   sign   sign of the term per lane
//
// Modports:
//   master  producer side (drives valid/last/term/sign, samples ready)
//   slave   consumer side (samples valid/last/term/sign, drives ready)
// ---------------------------------------------------------------------------
interface term_budget_limiter_if #(
  parameter int NUM_LANES = 4
);

  logic                 valid;
  logic                 ready;
  logic                 last;
  logic [NUM_LANES-1:0] term;
  logic [NUM_LANES-1:0] sign;

  modport master (
    output valid,
    output last,
    output term,
    output sign,
    input  ready
  );

  modport slave (
    input  valid,
    input  last,
    input  term,
    input  sign,
    output ready
  );

endinterface

// File: rtl/term_budget_limiter.sv
// ---------------------------------------------------------------------------
// term_budget_limiter
//
// Purpose: bit-serial term-stream limiter placed between the term encoder
// and the bit-serial MAC array. Each accepted beat carries one term bit per
// lane; the block keeps or drops each term so that, within one group
// (framed by 'last'), no lane keeps more than LANE_BUDGET terms and/or the
// whole group keeps no more than GROUP_BUDGET terms. Lanes compete for the
// group budget in fixed priority, lane 0 first. Kept terms leave through a
// single registered output stage one cycle after acceptance; sign bits are
// zeroed wherever the term is not kept.
//
// Ports:
//   gated_clk   clock
//   reset       synchronous, active-high; discards the group in progress
//               and any held output beat
//   mode[1:0]   00 pass, 01 lane truncate, 10 group top-terms, 11 both;
//               sampled on the first accepted beat of each group
//   in_if       slave side of the input term stream (valid/ready/last/
//               term/sign)
//   out_if      master side of the output term stream
//   group_kept  kept-term count of the group in progress
//
// Optional feature (macro TERM_BUDGET_STATS_EN):
//   group_dropped  number of input terms dropped over the last completed
//                  group, saturating; loaded on each accepted last beat
//   stats_valid    one-cycle pulse coincident with the first cycle that
//                  the corresponding last beat is presented on out_if
// ---------------------------------------------------------------------------
module term_budget_limiter #(
  parameter int NUM_LANES    = 4,
  parameter int LANE_BUDGET  = 4,
  parameter int GROUP_BUDGET = 8,
  parameter int CNT_W        = 5
) (
  input  logic                         gated_clk,
  input  logic                         reset,
  input  logic [1:0]                   mode,
  term_budget_limiter_if.slave         in_if,
  term_budget_limiter_if.master        out_if,
  output logic [CNT_W-1:0]             group_kept
`ifdef TERM_BUDGET_STATS_EN
  ,
  output logic [CNT_W-1:0]             group_dropped,
  output logic                         stats_valid
`endif
);

  // Wide enough to add a full counter and a full-beat popcount without
  // wrapping, so saturation and budget comparisons are exact.
  localparam int SUM_W = CNT_W + $clog2(NUM_LANES + 1);

  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [SUM_W-1:0] CNT_MAX_W = SUM_W'(CNT_MAX);
  localparam logic [CNT_W-1:0] LANE_LIM  = CNT_W'(LANE_BUDGET);
  localparam logic [SUM_W-1:0] GROUP_LIM = SUM_W'(GROUP_BUDGET);

  // Group framing: IDLE means the next accepted beat opens a new group and
  // samples the mode input; ACTIVE means a group is open and the latched
  // mode governs.
  typedef enum logic {
    GRP_IDLE   = 1'b0,
    GRP_ACTIVE = 1'b1
  } grp_state_e;

  grp_state_e           grp_state_q, grp_state_d;
  logic [1:0]           mode_q, mode_d;
  logic [CNT_W-1:0]     lane_cnt_q [NUM_LANES];
  logic [CNT_W-1:0]     lane_cnt_d [NUM_LANES];
  logic [CNT_W-1:0]     group_kept_q, group_kept_d;

  logic                 out_valid_q, out_valid_d;
  logic                 out_last_q, out_last_d;
  logic [NUM_LANES-1:0] out_term_q, out_term_d;
  logic [NUM_LANES-1:0] out_sign_q, out_sign_d;

`ifdef TERM_BUDGET_STATS_EN
  logic [CNT_W-1:0]     drop_acc_q, drop_acc_d;
  logic [CNT_W-1:0]     group_dropped_q, group_dropped_d;
  logic                 stats_valid_q, stats_valid_d;
  logic [SUM_W-1:0]     drop_cnt;
  logic [SUM_W-1:0]     drop_total;
`endif

  logic                 in_ready;
  logic                 accept;
  logic [1:0]           eff_mode;
  logic [NUM_LANES-1:0] lane_pass;
  logic [NUM_LANES-1:0] kept;
  logic [SUM_W-1:0]     kept_cnt;
  logic [SUM_W-1:0]     group_base;
  logic [SUM_W-1:0]     group_sum;

  // The single output register can take a new beat whenever it is empty
  // or is being drained this cycle; in_valid never reaches out_valid
  // combinationally.
  assign in_ready    = !out_valid_q || out_if.ready;
  assign accept      = in_if.valid && in_ready;
  assign in_if.ready = in_ready;

  assign out_if.valid = out_valid_q;
  assign out_if.last  = out_last_q;
  assign out_if.term  = out_term_q;
  assign out_if.sign  = out_sign_q;
  assign group_kept   = group_kept_q;

`ifdef TERM_BUDGET_STATS_EN
  assign group_dropped = group_dropped_q;
  assign stats_valid   = stats_valid_q;
`endif

  // Keep/drop decision for the beat currently on the input. The first
  // beat of a group is judged with the live mode input, because that is
  // the beat that latches it. Lanes are walked from lane 0 upward and the
  // running kept count is added to the group total, which gives lower
  // lanes priority for whatever group budget is left.
  always_comb begin
    eff_mode   = (grp_state_q == GRP_IDLE) ? mode : mode_q;
    lane_pass  = '0;
    kept       = '0;
    kept_cnt   = '0;
    group_base = SUM_W'(group_kept_q);
    for (int i = 0; i < NUM_LANES; i++) begin
      lane_pass[i] = in_if.term[i] &&
                     (!eff_mode[0] || (lane_cnt_q[i] < LANE_LIM));
      if (lane_pass[i] &&
          (!eff_mode[1] || ((group_base + kept_cnt) < GROUP_LIM))) begin
        kept[i] = 1'b1;
      end
      kept_cnt = kept_cnt + SUM_W'(kept[i]);
    end
    group_sum = group_base + kept_cnt;
  end

`ifdef TERM_BUDGET_STATS_EN
  // Terms that arrived but were not kept, and the running group total
  // including this beat, clamped later to the counter range.
  always_comb begin
    drop_cnt = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      drop_cnt = drop_cnt + SUM_W'(in_if.term[i] && !kept[i]);
    end
    drop_total = SUM_W'(drop_acc_q) + drop_cnt;
  end
`endif

  // Group bookkeeping. Nothing moves without an accepted beat. An accepted
  // last beat closes the group, so every counter returns to zero and the
  // following beat re-samples the mode. Counters saturate rather than
  // wrap; in the budgeted modes they never get near the limit anyway.
  always_comb begin
    grp_state_d  = grp_state_q;
    mode_d       = mode_q;
    lane_cnt_d   = lane_cnt_q;
    group_kept_d = group_kept_q;
    if (accept) begin
      mode_d = eff_mode;
      if (in_if.last) begin
        grp_state_d  = GRP_IDLE;
        group_kept_d = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
          lane_cnt_d[i] = '0;
        end
      end else begin
        grp_state_d  = GRP_ACTIVE;
        group_kept_d = (group_sum > CNT_MAX_W) ? CNT_MAX
                                               : group_sum[CNT_W-1:0];
        for (int i = 0; i < NUM_LANES; i++) begin
          if (kept[i] && (lane_cnt_q[i] != CNT_MAX)) begin
            lane_cnt_d[i] = lane_cnt_q[i] + CNT_W'(1);
          end
        end
      end
    end
  end

  // Output stage. An accepted beat loads the register; otherwise the
  // register holds, and only the valid flag drops once downstream has
  // taken the beat. Sign bits are masked by the kept term in every mode.
  always_comb begin
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_term_d  = out_term_q;
    out_sign_d  = out_sign_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_last_d  = in_if.last;
      out_term_d  = kept;
      out_sign_d  = in_if.sign & kept;
    end else if (out_if.ready) begin
      out_valid_d = 1'b0;
    end
  end

`ifdef TERM_BUDGET_STATS_EN
  // Dropped-term statistics. The accumulator covers the open group; the
  // reported value is loaded when the group's last beat is accepted, and
  // the pulse lines up with that beat's first cycle on the output.
  always_comb begin
    drop_acc_d      = drop_acc_q;
    group_dropped_d = group_dropped_q;
    stats_valid_d   = 1'b0;
    if (accept) begin
      if (in_if.last) begin
        drop_acc_d      = '0;
        group_dropped_d = (drop_total > CNT_MAX_W) ? CNT_MAX
                                                   : drop_total[CNT_W-1:0];
        stats_valid_d   = 1'b1;
      end else begin
        drop_acc_d = (drop_total > CNT_MAX_W) ? CNT_MAX
                                              : drop_total[CNT_W-1:0];
      end
    end
  end
`endif

  // All state of the block lives here; reset throws away the open group
  // and any beat still waiting in the output register.
  always_ff @(posedge gated_clk) begin
    if (reset) begin
      grp_state_q  <= GRP_IDLE;
      mode_q       <= 2'b00;
      group_kept_q <= '0;
      for (int i = 0; i < NUM_LANES; i++) begin
        lane_cnt_q[i] <= '0;
      end
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_term_q   <= '0;
      out_sign_q   <= '0;
`ifdef TERM_BUDGET_STATS_EN
      drop_acc_q      <= '0;
      group_dropped_q <= '0;
      stats_valid_q   <= 1'b0;
`endif
    end else begin
      grp_state_q  <= grp_state_d;
      mode_q       <= mode_d;
      group_kept_q <= group_kept_d;
      for (int i = 0; i < NUM_LANES; i++) begin
        lane_cnt_q[i] <= lane_cnt_d[i];
      end
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      out_term_q   <= out_term_d;
      out_sign_q   <= out_sign_d;
`ifdef TERM_BUDGET_STATS_EN
      drop_acc_q      <= drop_acc_d;
      group_dropped_q <= group_dropped_d;
      stats_valid_q   <= stats_valid_d;
`endif
    end
  end

endmodule

// File: tb/tb_term_budget_limiter.sv
// ---------------------------------------------------------------------------
// tb_term_budget_limiter
//
// Purpose: self-checking bench for term_budget_limiter. Every cycle is one
// directed or random step; after each edge the DUT is compared with a
// transaction-level reference model (per-lane and per-group counts kept as
// plain integers, group budget applied as "first N passing lanes").
// Directed steps additionally pin hand-derived constants.
// Optional feature macro honoured: TERM_BUDGET_STATS_EN.
// ---------------------------------------------------------------------------
module tb_term_budget_limiter;

  localparam int NUM_LANES    = 4;
  localparam int LANE_BUDGET  = 4;
  localparam int GROUP_BUDGET = 8;
  localparam int CNT_W        = 5;
  localparam int CNT_MAX      = (1 << CNT_W) - 1;

  logic             gated_clk;
  logic             reset;
  logic [1:0]       mode;
  logic [CNT_W-1:0] group_kept;
`ifdef TERM_BUDGET_STATS_EN
  logic [CNT_W-1:0] group_dropped;
  logic             stats_valid;
`endif

  term_budget_limiter_if #(.NUM_LANES(NUM_LANES)) in_bus ();
  term_budget_limiter_if #(.NUM_LANES(NUM_LANES)) out_bus ();

  term_budget_limiter #(
    .NUM_LANES   (NUM_LANES),
    .LANE_BUDGET (LANE_BUDGET),
    .GROUP_BUDGET(GROUP_BUDGET),
    .CNT_W       (CNT_W)
  ) dut (
    .gated_clk (gated_clk),
    .reset     (reset),
    .mode      (mode),
    .in_if     (in_bus),
    .out_if    (out_bus),
    .group_kept(group_kept)
`ifdef TERM_BUDGET_STATS_EN
    ,
    .group_dropped(group_dropped),
    .stats_valid  (stats_valid)
`endif
  );

  initial gated_clk = 1'b0;
  always #5 gated_clk = ~gated_clk;

  int vectors;
  int miscompares;

  // Reference model state, in transaction terms.
  int       lane_cnt_m [NUM_LANES];
  int       group_m;
  logic [1:0] mode_m;
  bit       in_group_m;
  int       drop_acc_m;
  bit       exp_valid;
  bit       exp_last;
  logic [NUM_LANES-1:0] exp_term;
  logic [NUM_LANES-1:0] exp_sign;
  int       exp_dropped;
  bit       exp_stats;

  task automatic checkValue(input string tag, input logic [31:0] observed,
                            input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < NUM_LANES; i++) lane_cnt_m[i] = 0;
    group_m     = 0;
    mode_m      = 2'b00;
    in_group_m  = 1'b0;
    drop_acc_m  = 0;
    exp_valid   = 1'b0;
    exp_last    = 1'b0;
    exp_term    = '0;
    exp_sign    = '0;
    exp_dropped = 0;
    exp_stats   = 1'b0;
  endtask

  // One accepted beat: lanes that still have lane budget (if enforced) are
  // listed in lane order, then only as many as the group has room for
  // survive.
  task automatic modelBeat(input bit l, input logic [NUM_LANES-1:0] t,
                           input logic [NUM_LANES-1:0] s, input logic [1:0] md);
    logic [1:0] eff;
    int passing[$];
    int allowed;
    int n_kept;
    int n_drop;
    logic [NUM_LANES-1:0] k;
    eff = in_group_m ? mode_m : md;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (t[i] && (!eff[0] || lane_cnt_m[i] < LANE_BUDGET)) passing.push_back(i);
    end
    allowed = NUM_LANES;
    if (eff[1]) allowed = (GROUP_BUDGET > group_m) ? GROUP_BUDGET - group_m : 0;
    k = '0;
    for (int n = 0; n < passing.size() && n < allowed; n++) k[passing[n]] = 1'b1;
    n_kept = $countones(k);
    n_drop = $countones(t & ~k);
    exp_valid = 1'b1;
    exp_term  = k;
    exp_sign  = s & k;
    exp_last  = l;
    if (l) begin
      for (int i = 0; i < NUM_LANES; i++) lane_cnt_m[i] = 0;
      group_m     = 0;
      in_group_m  = 1'b0;
      exp_dropped = (drop_acc_m + n_drop > CNT_MAX) ? CNT_MAX : drop_acc_m + n_drop;
      drop_acc_m  = 0;
      exp_stats   = 1'b1;
    end else begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (k[i] && lane_cnt_m[i] < CNT_MAX) lane_cnt_m[i]++;
      end
      group_m    = (group_m + n_kept > CNT_MAX) ? CNT_MAX : group_m + n_kept;
      drop_acc_m = (drop_acc_m + n_drop > CNT_MAX) ? CNT_MAX : drop_acc_m + n_drop;
      in_group_m = 1'b1;
      mode_m     = eff;
    end
  endtask

  task automatic checkOutput();
    checkValue("out_valid", 32'(out_bus.valid), 32'(exp_valid));
    checkValue("out_term", 32'(out_bus.term), 32'(exp_term));
    checkValue("out_sign", 32'(out_bus.sign), 32'(exp_sign));
    checkValue("out_last", 32'(out_bus.last), 32'(exp_last));
    checkValue("group_kept", 32'(group_kept), 32'(group_m));
`ifdef TERM_BUDGET_STATS_EN
    checkValue("group_dropped", 32'(group_dropped), 32'(exp_dropped));
    checkValue("stats_valid", 32'(stats_valid), 32'(exp_stats));
`endif
  endtask

  // One clock cycle: drive inputs just after an edge, check in_ready, let
  // the model take the beat if the model says it is accepted, clock, then
  // compare all outputs one time unit after the edge.
  task automatic applyStimulus(input bit rst, input bit v, input bit l,
                               input logic [NUM_LANES-1:0] t,
                               input logic [NUM_LANES-1:0] s,
                               input logic [1:0] md, input bit ordy);
    bit model_ready;
    reset          = rst;
    mode           = md;
    in_bus.valid   = v;
    in_bus.last    = l;
    in_bus.term    = t;
    in_bus.sign    = s;
    out_bus.ready  = ordy;
    #2;
    model_ready = !exp_valid || ordy;
    checkValue("in_ready", 32'(in_bus.ready), 32'(model_ready));
    if (rst) begin
      modelReset();
    end else begin
      exp_stats = 1'b0;
      if (v && model_ready) modelBeat(l, t, s, md);
      else if (ordy) exp_valid = 1'b0;
    end
    @(posedge gated_clk);
    #1;
    checkOutput();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    modelReset();
    reset         = 1'b1;
    mode          = 2'b00;
    in_bus.valid  = 1'b0;
    in_bus.last   = 1'b0;
    in_bus.term   = '0;
    in_bus.sign   = '0;
    out_bus.ready = 1'b1;

    // Reset state
    applyStimulus(1, 0, 0, 4'b0000, 4'b0000, 2'b00, 1);
    applyStimulus(1, 0, 0, 4'b0000, 4'b0000, 2'b00, 0);
    checkValue("rst_out_valid", 32'(out_bus.valid), 32'd0);
    checkValue("rst_out_term", 32'(out_bus.term), 32'd0);
    checkValue("rst_group_kept", 32'(group_kept), 32'd0);
    checkValue("rst_in_ready", 32'(in_bus.ready), 32'd1);

    // Mode 00 pass-through with sign masking
    applyStimulus(0, 1, 0, 4'b1011, 4'b1111, 2'b00, 1);
    checkValue("pass_term", 32'(out_bus.term), 32'b1011);
    checkValue("pass_sign", 32'(out_bus.sign), 32'b1011);
    checkValue("pass_last0", 32'(out_bus.last), 32'd0);
    applyStimulus(0, 1, 1, 4'b1011, 4'b1111, 2'b00, 1);
    checkValue("pass_last1", 32'(out_bus.last), 32'd1);

    // Mode 01 lane truncation: lane 0 on six beats
    for (int b = 1; b <= 6; b++) begin
      applyStimulus(0, 1, b == 6, 4'b0001, 4'b0001, 2'b01, 1);
      if (b == 4) checkValue("lane_b4", 32'(out_bus.term), 32'b0001);
      if (b == 5) begin
        checkValue("lane_b5", 32'(out_bus.term), 32'b0000);
        checkValue("lane_kept4", 32'(group_kept), 32'd4);
      end
    end
    applyStimulus(0, 1, 1, 4'b0001, 4'b0000, 2'b01, 1);
    checkValue("lane_restart", 32'(out_bus.term), 32'b0001);

    // Mode 10 group budget
    applyStimulus(0, 1, 0, 4'b1111, 4'b0101, 2'b10, 1);
    applyStimulus(0, 1, 0, 4'b1111, 4'b0101, 2'b10, 1);
    checkValue("grp_b2", 32'(out_bus.term), 32'b1111);
    checkValue("grp_kept8", 32'(group_kept), 32'd8);
    applyStimulus(0, 1, 1, 4'b1111, 4'b0101, 2'b10, 1);
    checkValue("grp_b3", 32'(out_bus.term), 32'b0000);
`ifdef TERM_BUDGET_STATS_EN
    checkValue("grp_dropped4", 32'(group_dropped), 32'd4);
    checkValue("grp_stats", 32'(stats_valid), 32'd1);
`endif
    applyStimulus(0, 1, 0, 4'b1111, 4'b1111, 2'b10, 1);
    applyStimulus(0, 1, 0, 4'b0111, 4'b1111, 2'b10, 1);
    applyStimulus(0, 1, 1, 4'b0110, 4'b1111, 2'b10, 1);
    checkValue("grp_priority", 32'(out_bus.term), 32'b0010);

    // Mode 11, with a mid-group mode change that must be ignored
    applyStimulus(0, 1, 0, 4'b1111, 4'b0000, 2'b11, 1);
    applyStimulus(0, 1, 0, 4'b1111, 4'b0000, 2'b11, 1);
    checkValue("both_b2", 32'(out_bus.term), 32'b1111);
    applyStimulus(0, 1, 0, 4'b1111, 4'b0000, 2'b00, 1);
    checkValue("both_b3", 32'(out_bus.term), 32'b0000);
    applyStimulus(0, 1, 0, 4'b1111, 4'b0000, 2'b11, 1);
    checkValue("both_kept8", 32'(group_kept), 32'd8);
    applyStimulus(0, 1, 1, 4'b0001, 4'b0001, 2'b11, 1);
    checkValue("both_b5", 32'(out_bus.term), 32'b0000);

    // Backpressure
    applyStimulus(0, 0, 0, 4'b0000, 4'b0000, 2'b00, 1);
    applyStimulus(0, 1, 0, 4'b0101, 4'b0100, 2'b00, 0);
    for (int c = 0; c < 3; c++) begin
      applyStimulus(0, 1, 1, 4'b1001, 4'b1000, 2'b00, 0);
      checkValue("bp_in_ready", 32'(in_bus.ready), 32'd0);
      checkValue("bp_term_hold", 32'(out_bus.term), 32'b0101);
      checkValue("bp_kept_frozen", 32'(group_kept), 32'd2);
    end
    applyStimulus(0, 1, 1, 4'b1001, 4'b1000, 2'b00, 1);
    checkValue("bp_release", 32'(out_bus.term), 32'b1001);
    applyStimulus(0, 0, 0, 4'b0000, 4'b0000, 2'b00, 1);

    // Reset in the middle of a group with a held output beat
    applyStimulus(0, 1, 0, 4'b1111, 4'b0000, 2'b10, 0);
    applyStimulus(1, 0, 0, 4'b0000, 4'b0000, 2'b10, 0);
    checkValue("midrst_valid", 32'(out_bus.valid), 32'd0);
    checkValue("midrst_kept", 32'(group_kept), 32'd0);
    applyStimulus(0, 1, 0, 4'b1111, 4'b0000, 2'b10, 1);
    applyStimulus(0, 1, 1, 4'b1111, 4'b0000, 2'b10, 1);
    checkValue("midrst_fresh", 32'(out_bus.term), 32'b1111);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 3) == 0, 4'($urandom), 4'($urandom),
                    2'($urandom), $urandom_range(0, 9) < 7);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/term_budget_limiter.md
Name: term_budget_limiter

Overview:
- Bit-serial term-stream limiter for term-quantized operands. Sits between the term encoder and the bit-serial MAC array.
- Enforces a per-lane term budget, a per-group term budget, or both, across NUM_LANES parallel lanes.
- Handles explicit group framing, valid/ready flow control and a registered output stage.
- Replaces the fixed 4-lane, free-running comparator/truncator; it adds group restart and deterministic lane priority, and gates sign bits with the kept term.

Parameters:
NUM_LANES, 4, number of parallel term lanes
LANE_BUDGET, 4, max kept terms per lane per group
GROUP_BUDGET, 8, max kept terms summed over all lanes per group
CNT_W, 5, counter width; requires GROUP_BUDGET < 2^CNT_W and LANE_BUDGET < 2^CNT_W

Ports:
gated_clk  input  1  clock
reset  input  1  synchronous, active-high
mode  input  2  00 pass, 01 lane truncate, 10 group top-terms, 11 both
in_valid  input  1  input beat valid
in_ready  output  1  block can accept beat
in_last  input  1  final beat of current group
in_term  input  NUM_LANES  term-present bit per lane
in_sign  input  NUM_LANES  sign of term per lane
out_valid  output  1  output beat valid
out_ready  input  1  downstream accepts beat
out_last  output  1  final beat of group
out_term  output  NUM_LANES  kept term bits
out_sign  output  NUM_LANES  sign bits, forced 0 where out_term is 0
group_kept  output  CNT_W  kept-term count of the group in progress

Behaviour:
- Reset: out_valid=0, out_term=0, out_sign=0, out_last=0, group_kept=0, all lane counters 0, in_ready=1, active mode=00. Reset mid-group discards the group, including any held output beat.
- Accept: a beat is accepted when in_valid && in_ready. in_ready = !out_valid || out_ready (single output register, no combinational path from in_valid to out_valid).
- Latency: 1 cycle from acceptance to out_valid. The output register holds its value while out_valid && !out_ready.
- Mode is latched on the first accepted beat of each group; mode changes mid-group are ignored until the next group.
- Lane check (mode bit0): lane i passes if in_term[i] && lane_cnt[i] < LANE_BUDGET. When mode bit0=0, in_term[i] alone passes.
- Group check (mode bit1): lanes are evaluated lane 0 first. Lane i is kept if it passes the lane check and group_kept + (number of lower lanes kept this beat) < GROUP_BUDGET. When mode bit1=0, every lane that passes the lane check is kept.
- Kept bit: out_term[i] = kept[i]; out_sign[i] = in_sign[i] && kept[i]; out_last = in_last.
- Counters advance only on accepted beats:
  - lane_cnt[i] increments by kept[i].
  - group_kept increments by popcount(kept), saturating at 2^CNT_W-1. Budget enforcement keeps the count ≤ GROUP_BUDGET in modes 10/11.
- Group restart: on an accepted beat with in_last=1, all counters clear to 0 on the next edge. The next beat starts a fresh group and re-latches mode.
- Single-beat group (first beat also last): budgets apply to that beat, then counters clear.
- Budget of 0: nothing is kept in the corresponding check; the stream still flows with zero terms.
- Mode 00: pure 1-cycle registered pass-through, but signs are still masked by term.
- No accepted beat: counters, mode and output are unchanged, except that out_valid clears when out_ready && !(in_valid && in_ready).

Optional Feature:
- Macro: TERM_BUDGET_STATS_EN.
- When defined:
  - Adds output port group_dropped [CNT_W].
  - On each accepted in_last beat, group_dropped loads the total count of in_term bits dropped (input terms not kept) over that group, saturating.
  - Adds output port stats_valid, which pulses 1 cycle coincident with that out_valid/out_last beat.
  - Both reset to 0.
- When undefined: neither port nor its logic exists; the core behaviour is identical.

Test Plan:
- Reset, then mode=00, beats 4'b1011/sign 4'b1111 with last on beat 2 -> out_term 4'b1011, out_sign 4'b1011 one cycle later, out_last on beat 2.
- mode=01, LANE_BUDGET=4: lane 0 term on 6 consecutive beats -> kept on beats 1-4, dropped on 5-6; group_kept=4. Next group, after last: lane 0 kept again on its first beat.
- mode=10, GROUP_BUDGET=8: 3 beats of 4'b1111 -> beat1 1111, beat2 1111, beat3 0000; a subsequent beat 4'b0110 with 7 already kept -> 0010 (lane priority to lane 1).
- mode=11, one beat each: 4'b1111 ×4 then lane 0 only -> lane-0 cap at 4, group cap at 8 reached after beat 2, all later terms dropped.
- Backpressure: hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, out registers stable, counters frozen. Release -> beats delivered in order, none lost or duplicated.
- Reset asserted mid-group with out_valid=1 -> next cycle out_valid=0, group_kept=0; the following group starts with fresh budgets. With TERM_BUDGET_STATS_EN, group_dropped reports 4 for the mode=10 case above.
